sonic_obstacle_filter: RTL
==========================

// Module: sonic_obstacle_filter
// PURPOSE
//  Consumes the 20-bit distance (mm) produced by the ultrasonic ranging block.
//  Samples it once per trigger period, rejects out-of-range readings and
//  produces a 4-tap moving average. Drives a debounced, hysteretic obstacle flag
//  for the motion/control logic downstream.
// PARAMETERS
//  SAMPLE_PERIOD  10_000_000  clk cycles between samples (matches 100 ms trigger)
//  NEAR_TH        200         avg below this (mm) counts as "near"
//  FAR_TH         250         avg above this (mm) counts as "far"; NEAR_TH < FAR_TH
//  CONFIRM        3           consecutive qualifying averages needed to switch state (>=1)
//  MAX_VALID      4000        readings > MAX_VALID or ==0 are invalid
// PORTS
//  clk         in   1   system clock (100 MHz)
//  rst         in   1   asynchronous, active-high reset
//  en          in   1   1 = run; 0 = hold block cleared
//  distance    in   20  raw distance in mm from ranging block (other clk domain)
//  dist_avg    out  20  4-sample moving average, mm
//  avg_valid   out  1   1-cycle pulse: dist_avg updated this cycle
//  obstacle    out  1   debounced obstacle flag
//  sample_err  out  1   1-cycle pulse: sample at tick rejected
// BEHAVIOUR
//  Reset: dist_avg=0, avg_valid=0, obstacle=0, sample_err=0; tick counter=0,
//   history and fill count=0, FSM=FAR. Reset mid-operation aborts everything.
//  en=0: same clearing as reset (except input sync regs), applied synchronously.
//  Input sync: distance passes two flops every clk (d_s1, d_s2); only d_s2 used.
//  Tick counter: counts 0..SAMPLE_PERIOD-1 while en=1, wraps to 0. Tick cycle T =
//   counter==SAMPLE_PERIOD-1. First tick is SAMPLE_PERIOD cycles after en rises.
//  Cycle T: sample = d_s2. Invalid if sample==0 or sample>MAX_VALID.
//  Invalid: sample_err=1 in T+1; history, fill, avg unchanged; no avg_valid.
//  Valid: end of T shift sample into 4-entry history h0..h3 (h0 newest), fill
//   saturates at 4. End of T+1: 22-bit sum h0+h1+h2+h3 registered (cannot
//   overflow). In T+2, if fill==4: dist_avg = sum>>2 (truncate), avg_valid=1.
//   With fill<4, no avg_valid and dist_avg keeps its old value.
//  Obstacle FSM (advances only in cycles with avg_valid=1; pend counter cnt):
//   FAR:       avg<NEAR_TH -> NEAR (CONFIRM==1) else NEAR_PEND, cnt=1
//   NEAR_PEND: avg<NEAR_TH -> cnt+1; cnt+1==CONFIRM -> NEAR; avg>=NEAR_TH -> FAR
//   NEAR:      avg>FAR_TH  -> FAR (CONFIRM==1) else FAR_PEND, cnt=1
//   FAR_PEND:  avg>FAR_TH  -> cnt+1; cnt+1==CONFIRM -> FAR; avg<=FAR_TH -> NEAR
//   NEAR_TH<=avg<=FAR_TH never changes the flag. Illegal state encoding -> FAR.
//  obstacle is registered: 1 in NEAR and FAR_PEND, updates in T+3.
//  Tick coinciding with en falling: en wins, sample discarded.
// TESTING (bench uses SAMPLE_PERIOD=8, defaults otherwise)
//  1 Reset, then distance=500 held: 3 ticks no avg_valid; 4th tick -> avg_valid
//    in T+2 with dist_avg=500, obstacle=0, sample_err never set.
//  2 Samples 100,200,300,400 -> dist_avg=250; then 1001,1000,1000,1000 -> 1000
//    (truncation); pulse width exactly 1 cycle, spacing 8 cycles.
//  3 distance=0 at a tick, later 4100 at a tick -> sample_err pulse each in T+1,
//    no avg_valid, following valid sample averages with prior history intact.
//  4 Averages 150,150,150 -> obstacle rises after 3rd; 220 -> stays 1;
//    300,300,220 -> stays 1; 300,300,300 -> falls after 3rd.
//  5 rst pulse while in NEAR_PEND (cnt=2) -> all outputs 0 immediately; four
//    fresh valid samples required before next avg_valid.
//  6 en low 1 cycle after fill==4 -> history cleared, next tick 8 cycles after
//    en returns, avg_valid only after 4 new valid samples.

Source files
------------

// File: rtl/sonic_obstacle_filter.sv
// rtl/sonic_obstacle_filter.sv - sampled ultrasonic distance filter with 4-tap average
// and a debounced, hysteretic obstacle flag.
module sonic_obstacle_filter #(
   parameter int SAMPLE_PERIOD = 10_000_000,
   parameter int NEAR_TH       = 200,
   parameter int FAR_TH        = 250,
   parameter int CONFIRM       = 3,
   parameter int MAX_VALID     = 4000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [19:0] distance,
   output logic [19:0] dist_avg,
   output logic        avg_valid,
   output logic        obstacle,
   output logic        sample_err
);

   localparam int TW = $clog2(SAMPLE_PERIOD + 1);
   localparam int CW = $clog2(CONFIRM + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM);
   localparam logic [19:0]   NEAR_C    = 20'(NEAR_TH);
   localparam logic [19:0]   FAR_C     = 20'(FAR_TH);
   localparam logic [19:0]   MAX_C     = 20'(MAX_VALID);

   typedef enum logic [1:0] {FAR, NEAR_PEND, NEAR, FAR_PEND} state_t;

   logic [19:0]   d_s1, d_s2;
   logic [TW-1:0] tick_cnt;
   logic          tick, sample_ok;
   logic [19:0]   h0, h1, h2, h3;
   logic [2:0]    fill;
   logic          shifted;
   logic [21:0]   hist_sum;
   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;

   assign tick      = en && (tick_cnt == TICK_LAST);
   assign sample_ok = (d_s2 != 20'd0) && (d_s2 <= MAX_C);
   assign hist_sum  = {2'b00, h0} + {2'b00, h1} + {2'b00, h2} + {2'b00, h3};
   assign cnt_inc   = cnt + 1'b1;

   // distance comes from another clock domain; only d_s2 is ever consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_s1 <= '0;
         d_s2 <= '0;
      end else begin
         d_s1 <= distance;
         d_s2 <= d_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt   <= '0;
         sample_err <= 1'b0;
         shifted    <= 1'b0;
         {h0, h1, h2, h3} <= '0;
         fill       <= '0;
         dist_avg   <= '0;
         avg_valid  <= 1'b0;
      end else if (!en) begin
         tick_cnt   <= '0;
         sample_err <= 1'b0;
         shifted    <= 1'b0;
         {h0, h1, h2, h3} <= '0;
         fill       <= '0;
         dist_avg   <= '0;
         avg_valid  <= 1'b0;
      end else begin
         tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
         sample_err <= tick && !sample_ok;
         shifted    <= tick && sample_ok;
         if (tick && sample_ok) begin
            {h0, h1, h2, h3} <= {d_s2, h0, h1, h2};
            fill <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
         end
         // one cycle after the shift the history is settled; publish only once full
         avg_valid <= shifted && (fill == 3'd4);
         if (shifted && (fill == 3'd4))
            dist_avg <= hist_sum[21:2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FAR;
         cnt      <= '0;
         obstacle <= 1'b0;
      end else if (!en) begin
         state    <= FAR;
         cnt      <= '0;
         obstacle <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         obstacle <= (state_nx == NEAR) || (state_nx == FAR_PEND);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         FAR: if (avg_valid && dist_avg < NEAR_C) begin
            if (CONFIRM == 1) state_nx = NEAR;
            else begin
               state_nx = NEAR_PEND;
               cnt_nx   = CW'(1);
            end
         end
         NEAR_PEND: if (avg_valid) begin
            if (dist_avg < NEAR_C) begin
               if (cnt_inc == CONFIRM_C) state_nx = NEAR;
               else cnt_nx = cnt_inc;
            end else state_nx = FAR;
         end
         NEAR: if (avg_valid && dist_avg > FAR_C) begin
            if (CONFIRM == 1) state_nx = FAR;
            else begin
               state_nx = FAR_PEND;
               cnt_nx   = CW'(1);
            end
         end
         FAR_PEND: if (avg_valid) begin
            if (dist_avg > FAR_C) begin
               if (cnt_inc == CONFIRM_C) state_nx = FAR;
               else cnt_nx = cnt_inc;
            end else state_nx = NEAR;
         end
         default: state_nx = FAR;
      endcase
   end

endmodule
